// File: rtl/coin_pkg.sv
// Shared types and constants for the coin/barrier spawners: lane codes, spawner
// FSM states and the LFSR feedback mask.
package coin_pkg;

  typedef enum logic [1:0] {
    LANE_NONE  = 2'b00,
    LANE_LEFT  = 2'b01,
    LANE_MID   = 2'b10,
    LANE_RIGHT = 2'b11
  } lane_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GAP    = 2'b01,
    ACTIVE = 2'b10,
    HIT    = 2'b11
  } spawn_state_t;

  // Feedback mask for taps 16,14,13,11 in a left-shifting register
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam int          MAX_EXTRA_GAP = 15;

  // Random lane with 00 folded onto LEFT; a clash with the barrier rotates to the next lane.
  function automatic lane_t pick_lane(input logic [1:0] rnd, input lane_t barrier);
    lane_t raw;
    raw = (rnd == 2'b00) ? LANE_LEFT : lane_t'(rnd);
    if ((barrier != LANE_NONE) && (raw == barrier))
      raw = (raw == LANE_RIGHT) ? LANE_LEFT : lane_t'(raw + 2'b01);
    return raw;
  endfunction

endpackage

// File: rtl/coin_spawner_if.sv
// Control/status bundle between the game sequencer and the coin spawner.
// master drives the game inputs, slave is the spawner itself.
interface coin_spawner_if;
  logic       i_v_sync;
  logic       i_enable;
  logic       i_penguin_hit;
  logic [1:0] i_barrier_lane;
  logic [1:0] o_active;
  logic       o_spawn;
  logic [7:0] o_coin_count;

  modport master (
    output i_v_sync, i_enable, i_penguin_hit, i_barrier_lane,
    input  o_active, o_spawn, o_coin_count
  );

  modport slave (
    input  i_v_sync, i_enable, i_penguin_hit, i_barrier_lane,
    output o_active, o_spawn, o_coin_count
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, advances one step per cycle with i_adv high.
// Zero latency on o_state; no backpressure. Seed must be nonzero.
module lfsr16
  import coin_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_adv,
  output logic [15:0] o_state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (i_adv)
      state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= SEED;
    else          state_q <= state_d;
  end

  assign o_state = state_q;

endmodule

// File: rtl/coin_spawner.sv
// Coin spawner: frame-timed gap/lifetime FSM driving the lane select; COIN_SPEEDUP_EN shortens lifetime with play.
// Lane appears 1 cycle after the spawning frame tick; no backpressure, a held hit parks the FSM in HIT.
module coin_spawner
  import coin_pkg::*;
#(
  parameter int          COIN_LIFE = 90,
  parameter int          MIN_GAP   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  coin_spawner_if.slave bus
);

  localparam int GAP_MAX = MIN_GAP + MAX_EXTRA_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int LIFE_W  = $clog2(COIN_LIFE + 1);

  logic              vs_meta_q, vs_sync_q;
  logic              tick;
  logic [15:0]       lfsr;
  logic [11:0]       lfsr_unused;
  logic [GAP_W-1:0]  gap_load;
  logic [LIFE_W-1:0] life_load;

  spawn_state_t      state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [LIFE_W-1:0] life_cnt_q, life_cnt_d;
  lane_t             lane_q, lane_d;
  lane_t             active_q, active_d;
  logic              spawn_q, spawn_d;
  logic [7:0]        coin_count_q, coin_count_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
    end else begin
      vs_meta_q <= bus.i_v_sync;
      vs_sync_q <= vs_meta_q;
    end
  end

  assign tick = vs_meta_q & ~vs_sync_q;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_adv   (tick),
    .o_state (lfsr)
  );

  assign lfsr_unused = lfsr[15:4];
  assign gap_load    = GAP_W'(MIN_GAP + int'(lfsr[3:0]));

`ifdef COIN_SPEEDUP_EN
  // Lifetime drops by 8 frames every 8 coins, floored at half the base lifetime.
  int life_dec;
  always_comb begin
    life_dec = 8 * int'(coin_count_q[7:3]);
    if (COIN_LIFE - life_dec < COIN_LIFE / 2) life_load = LIFE_W'(COIN_LIFE / 2);
    else                                      life_load = LIFE_W'(COIN_LIFE - life_dec);
  end
`else
  assign life_load = LIFE_W'(COIN_LIFE);
`endif

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    life_cnt_d   = life_cnt_q;
    lane_d       = lane_q;
    spawn_d      = 1'b0;
    coin_count_d = coin_count_q;

    if (!bus.i_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = GAP;
          gap_cnt_d = gap_load;
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt_q <= GAP_W'(1)) begin
              state_d    = ACTIVE;
              lane_d     = pick_lane(lfsr[1:0], lane_t'(bus.i_barrier_lane));
              life_cnt_d = life_load;
              spawn_d    = 1'b1;
              if (coin_count_q != 8'hFF) coin_count_d = coin_count_q + 8'd1;
            end else begin
              gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
          end
        end
        ACTIVE: begin
          // A hit takes priority over lifetime expiry in the same cycle
          if (bus.i_penguin_hit) begin
            state_d = HIT;
          end else if (tick) begin
            if (life_cnt_q <= LIFE_W'(1)) begin
              state_d   = GAP;
              gap_cnt_d = gap_load;
            end else begin
              life_cnt_d = life_cnt_q - LIFE_W'(1);
            end
          end
        end
        HIT: begin
          // Generator clears its hit flag only once it sees active==00
          if (!bus.i_penguin_hit) begin
            state_d   = GAP;
            gap_cnt_d = gap_load;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    active_d = (state_d == ACTIVE) ? lane_d : LANE_NONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      life_cnt_q   <= '0;
      lane_q       <= LANE_NONE;
      active_q     <= LANE_NONE;
      spawn_q      <= 1'b0;
      coin_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      life_cnt_q   <= life_cnt_d;
      lane_q       <= lane_d;
      active_q     <= active_d;
      spawn_q      <= spawn_d;
      coin_count_q <= coin_count_d;
    end
  end

  assign bus.o_active     = active_q;
  assign bus.o_spawn      = spawn_q;
  assign bus.o_coin_count = coin_count_q;

endmodule

// File: tb/tb_coin_spawner.sv
// Directed bench for coin_spawner: frame-stepped stimulus with a reference LFSR
// predicting gap lengths and lanes.
module tb_coin_spawner;

  logic i_clk = 1'b0;
  logic i_rst_n;

  coin_spawner_if bus ();

  coin_spawner #(
    .COIN_LIFE (90),
    .MIN_GAP   (20),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          spawn_seen = 0;
  logic [1:0]  spawn_lane = 2'b00;
  logic [15:0] m_lfsr, m_prev;
  int          exp_count;
  bit          done10 = 1'b0;
  bit          done11 = 1'b0;

  always @(negedge i_clk) begin
    if (bus.o_spawn === 1'b1) begin
      spawn_seen++;
      spawn_lane = bus.o_active;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [1:0] raw_lane(input logic [15:0] s);
    return (s[1:0] == 2'b00) ? 2'b01 : s[1:0];
  endfunction

  function automatic logic [1:0] exp_pick(input logic [15:0] s, input logic [1:0] bar);
    logic [1:0] r;
    r = raw_lane(s);
    if (bar != 2'b00 && r == bar) r = (r == 2'b11) ? 2'b01 : r + 2'b01;
    return r;
  endfunction

  function automatic int exp_life(input int cnt_before);
    int v;
`ifdef COIN_SPEEDUP_EN
    v = 90 - 8 * (cnt_before / 8);
    if (v < 45) v = 45;
`else
    v = 90 + 0 * cnt_before;
`endif
    return v;
  endfunction

  // One video frame: v_sync high 2 cycles, low 2 cycles; exactly one tick inside.
  task automatic frame();
    bus.i_v_sync = 1'b1;
    repeat (2) @(negedge i_clk);
    bus.i_v_sync = 1'b0;
    repeat (2) @(negedge i_clk);
    m_prev = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // Runs a gap of g frames ending in a spawn. bar_mode < 0 picks a barrier automatically.
  task automatic run_gap(input int g, input int bar_mode, input string tag, output logic [1:0] lane);
    int         nz;
    int         sp0;
    logic [1:0] bar, raw, el;
    nz  = 0;
    sp0 = spawn_seen;
    bus.i_barrier_lane = 2'b00;
    for (int i = 1; i < g; i++) begin
      frame();
      if (bus.o_active !== 2'b00) nz++;
    end
    check_eq({tag, "_quiet"}, nz, 0);
    check_eq({tag, "_no_early_spawn"}, spawn_seen, sp0);
    raw = raw_lane(m_lfsr);
    if (bar_mode >= 0)                 bar = 2'(bar_mode);
    else if (!done10 && raw == 2'b10)  bar = 2'b10;
    else if (!done11 && raw == 2'b11)  bar = 2'b11;
    else                               bar = (raw == 2'b01) ? 2'b00 : 2'b01;
    bus.i_barrier_lane = bar;
    el = exp_pick(m_lfsr, bar);
    frame();
    if (exp_count < 255) exp_count++;
    check_eq({tag, "_one_pulse"}, spawn_seen, sp0 + 1);
    check_eq({tag, "_lane"}, bus.o_active, el);
    check_eq({tag, "_pulse_lane"}, spawn_lane, el);
    check_eq({tag, "_count"}, bus.o_coin_count, exp_count);
    if (bar == 2'b10 && raw == 2'b10) begin
      check_eq("bar10_lane", bus.o_active, 3);
      done10 = 1'b1;
    end
    if (bar == 2'b11 && raw == 2'b11) begin
      check_eq("bar11_lane", bus.o_active, 1);
      done11 = 1'b1;
    end
    lane = el;
  endtask

  // Lets an unhit coin live out its lifetime; returns the reloaded gap length.
  task automatic run_life(input int life, input logic [1:0] lane, input string tag, output int g);
    int bad;
    bad = 0;
    for (int i = 1; i < life; i++) begin
      frame();
      if (i == 1) bus.i_barrier_lane = lane;
      if (bus.o_active !== lane) bad++;
    end
    check_eq({tag, "_held"}, bad, 0);
    frame();
    check_eq({tag, "_expire"}, bus.o_active, 0);
    g = 20 + int'(m_prev[3:0]);
  endtask

  task automatic hit_cut(output int g);
    bus.i_penguin_hit = 1'b1;
    @(negedge i_clk);
    check_eq("cut_active", bus.o_active, 0);
    bus.i_penguin_hit = 1'b0;
    @(negedge i_clk);
    g = 20 + int'(m_lfsr[3:0]);
  endtask

  initial begin
    int         g, sp0, bad;
    logic [1:0] lane;

    bus.i_v_sync       = 1'b0;
    bus.i_enable       = 1'b0;
    bus.i_penguin_hit  = 1'b0;
    bus.i_barrier_lane = 2'b00;
    i_rst_n            = 1'b0;
    m_lfsr             = 16'hACE1;
    m_prev             = 16'hACE1;
    exp_count          = 0;

    repeat (3) @(negedge i_clk);
    check_eq("rst_active", bus.o_active, 0);
    check_eq("rst_spawn", bus.o_spawn, 0);
    check_eq("rst_count", bus.o_coin_count, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Disabled: frames tick the LFSR but nothing spawns
    for (int i = 0; i < 3; i++) frame();
    check_eq("idle_active", bus.o_active, 0);
    check_eq("idle_spawn", spawn_seen, 0);

    bus.i_enable = 1'b1;
    @(negedge i_clk);
    g = 20 + int'(m_lfsr[3:0]);
    run_gap(g, 0, "first", lane);

    run_life(exp_life(0), lane, "life", g);
    run_gap(g, 0, "gap2", lane);

    // Hit 10 frames into the coin
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      frame();
      if (bus.o_active !== lane) bad++;
    end
    check_eq("prehit_held", bad, 0);
    bus.i_penguin_hit = 1'b1;
    @(negedge i_clk);
    check_eq("hit_drop", bus.o_active, 0);
    sp0 = spawn_seen;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      frame();
      if (bus.o_active !== 2'b00) bad++;
    end
    check_eq("hit_hold_quiet", bad, 0);
    check_eq("hit_hold_nospawn", spawn_seen, sp0);
    bus.i_penguin_hit = 1'b0;
    @(negedge i_clk);
    g = 20 + int'(m_lfsr[3:0]);
    run_gap(g, 0, "after_hit", lane);

    // Enable drop mid-coin
    for (int i = 0; i < 5; i++) frame();
    bus.i_enable = 1'b0;
    @(negedge i_clk);
    check_eq("dis_active", bus.o_active, 0);
    sp0 = spawn_seen;
    for (int i = 0; i < 3; i++) frame();
    check_eq("dis_quiet", bus.o_active, 0);
    check_eq("dis_nospawn", spawn_seen, sp0);
    bus.i_enable = 1'b1;
    @(negedge i_clk);
    g = 20 + int'(m_lfsr[3:0]);
    run_gap(g, 0, "reenable", lane);

    // Asynchronous reset mid-coin
    for (int i = 0; i < 3; i++) frame();
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("arst_active", bus.o_active, 0);
    check_eq("arst_count", bus.o_coin_count, 0);
    check_eq("arst_spawn", bus.o_spawn, 0);
    @(negedge i_clk);
    i_rst_n   = 1'b1;
    m_lfsr    = 16'hACE1;
    exp_count = 0;
    @(negedge i_clk);
    g = 20 + int'(m_lfsr[3:0]);
    run_gap(g, -1, "post_rst", lane);

    // 300 spawns total since reset, each coin cut short by a hit
    for (int n = 2; n <= 300; n++) begin
      hit_cut(g);
      run_gap(g, -1, "sat", lane);
    end
    check_eq("sat_count", bus.o_coin_count, 255);
    check_eq("bar10_seen", done10, 1);
    check_eq("bar11_seen", done11, 1);

    run_life(exp_life(255), lane, "late_life", g);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
